// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an NxN weight-stationary systolic array: weight load,
// skewed activation streaming, drain and result-column flagging.
// Optional perf counter enabled by defining SYSTOLIC_PERF_CNT_EN.
module systolic_seq_ctrl #(
  parameter int ARRAY_SIZE = 4,
  parameter int VEC_W      = 8,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [VEC_W-1:0]      num_vecs,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  pe_load,
  output logic [(ARRAY_SIZE > 1 ? $clog2(ARRAY_SIZE) : 1)-1:0] w_rd_addr,
  output logic                  act_rd_en,
  output logic [VEC_W-1:0]      act_rd_addr,
  output logic [ARRAY_SIZE-1:0] act_row_en,
`ifdef SYSTOLIC_PERF_CNT_EN
  output logic [CNT_W-1:0]      perf_cycles,
`endif
  output logic [ARRAY_SIZE-1:0] res_col_valid
);

  localparam int N  = ARRAY_SIZE;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int L  = 2 * N - 1;
  localparam int CW = $clog2(2 * N);
  // t must reach num_vecs + 2N - 2 without wrapping
  localparam int TW = VEC_W + $clog2(2 * N) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [VEC_W-1:0] r_nv;
  logic [CW-1:0]    r_c;
  logic [TW-1:0]    r_t;

  state_t           w_nstate;
  logic [VEC_W-1:0] w_nnv;
  logic [CW-1:0]    w_nc;
  logic [TW-1:0]    w_nt;
  logic             w_accept;
  logic             w_last_stream;
  logic             w_last_drain;
  logic [TW-1:0]    w_nv_ext;
  logic             w_run;
  logic [AW-1:0]    w_addr_n;
  logic [N-1:0]     w_row_n;
  logic [N-1:0]     w_res_n;

  assign w_last_stream = (r_t == TW'(r_nv) - TW'(1));
  assign w_last_drain  = (r_t == TW'(r_nv) + TW'(2 * N - 2));

  // Next-state and counter update; outputs are derived from these
  always_comb begin
    w_nstate = r_state;
    w_nnv    = r_nv;
    w_nc     = r_c;
    w_nt     = r_t;
    w_accept = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_nnv    = num_vecs;
          w_nc     = '0;
          w_nt     = '0;
          w_nstate = (num_vecs != '0) ? S_LOAD : S_DONE;
        end
      end
      S_LOAD: begin
        if (abort) begin
          w_nstate = S_DONE;
        end else if (r_c == CW'(L - 1)) begin
          w_nstate = S_STREAM;
          w_nt     = '0;
        end else begin
          w_nc = r_c + CW'(1);
        end
      end
      S_STREAM: begin
        if (abort) begin
          w_nstate = S_DONE;
        end else begin
          w_nt = r_t + TW'(1);
          if (w_last_stream) w_nstate = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          w_nstate = S_DONE;
        end else if (w_last_drain) begin
          w_nstate = S_DONE;
        end else begin
          w_nt = r_t + TW'(1);
        end
      end
      S_DONE:  w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  assign w_nv_ext = TW'(w_nnv);
  assign w_run    = (w_nstate == S_STREAM) || (w_nstate == S_DRAIN);

  // Output values for the upcoming cycle, so the registers hold them then
  always_comb begin
    w_addr_n = '0;
    w_row_n  = '0;
    w_res_n  = '0;
    if (w_nstate == S_LOAD) begin
      w_addr_n = AW'(N - 1 - (int'(w_nc) >> 1));
    end
    for (int r = 0; r < N; r++) begin
      w_row_n[r] = w_run &&
                   (w_nt >= TW'(r)) &&
                   (w_nt < w_nv_ext + TW'(r));
      w_res_n[r] = w_run &&
                   (w_nt >= TW'(N + r)) &&
                   (w_nt < w_nv_ext + TW'(N + r));
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_nv          <= '0;
      r_c           <= '0;
      r_t           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pe_load       <= 1'b0;
      w_rd_addr     <= '0;
      act_rd_en     <= 1'b0;
      act_rd_addr   <= '0;
      act_row_en    <= '0;
      res_col_valid <= '0;
    end else begin
      r_state       <= w_nstate;
      r_nv          <= w_nnv;
      r_c           <= w_nc;
      r_t           <= w_nt;
      busy          <= (w_nstate == S_LOAD) || w_run;
      done          <= (w_nstate == S_DONE);
      pe_load       <= (w_nstate == S_LOAD);
      w_rd_addr     <= w_addr_n;
      act_rd_en     <= (w_nstate == S_STREAM);
      act_rd_addr   <= (w_nstate == S_STREAM) ? w_nt[VEC_W-1:0] : '0;
      act_row_en    <= w_row_n;
      res_col_valid <= w_res_n;
    end
  end

`ifdef SYSTOLIC_PERF_CNT_EN
  // Busy-cycle counter: cleared on accepted start, saturating
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cycles <= '0;
    end else if (w_accept) begin
      perf_cycles <= '0;
    end else if (busy && (perf_cycles != '1)) begin
      perf_cycles <= perf_cycles + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Self-checking bench for systolic_seq_ctrl: job-level reference model,
// directed literal checks, then randomized jobs with aborts.
module tb_systolic_seq_ctrl;

  localparam int N  = 4;
  localparam int VW = 8;
  localparam int CW = 32;
  localparam int L  = 2 * N - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [VW-1:0] num_vecs = '0;
  logic          abort = 1'b0;
  logic          busy, done, pe_load, act_rd_en;
  logic [1:0]    w_rd_addr;
  logic [VW-1:0] act_rd_addr;
  logic [N-1:0]  act_row_en, res_col_valid;
`ifdef SYSTOLIC_PERF_CNT_EN
  logic [CW-1:0] perf_cycles;
`endif

  systolic_seq_ctrl #(.ARRAY_SIZE(N), .VEC_W(VW), .CNT_W(CW)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .num_vecs(num_vecs),
    .abort(abort),
    .busy(busy),
    .done(done),
    .pe_load(pe_load),
    .w_rd_addr(w_rd_addr),
    .act_rd_en(act_rd_en),
    .act_rd_addr(act_rd_addr),
    .act_row_en(act_row_en),
`ifdef SYSTOLIC_PERF_CNT_EN
    .perf_cycles(perf_cycles),
`endif
    .res_col_valid(res_col_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model: mode 0 idle, 1 job running (k = cycles since accept), 2 done
  int m_mode = 0;
  int m_k = 0;
  int m_nv = 0;
  longint m_perf = 0;

  int rec_j = -1;
  int ob_busy[0:31], ob_pl[0:31], ob_wa[0:31], ob_done[0:31];
  int ob_ae[0:31], ob_aa[0:31], ob_r3[0:31], ob_c0[0:31], ob_c3[0:31];
  longint ob_perf[0:31];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    int t;
    int eb, ed, ep, eae;
    int er, ec;
    eb = 0; ed = 0; ep = 0; eae = 0; er = 0; ec = 0;
    if (m_mode == 1) begin
      eb = 1;
      if (m_k <= L) begin
        ep = 1;
        if (((m_k - 1) % 2) == 0)
          chk("w_rd_addr", int'(w_rd_addr), N - 1 - (m_k - 1) / 2);
      end else begin
        t = m_k - 1 - L;
        if (t < m_nv) begin
          eae = 1;
          chk("act_rd_addr", int'(act_rd_addr), t);
        end
        for (int r = 0; r < N; r++) begin
          if (t >= r && t < m_nv + r) er |= (1 << r);
          if (t >= N + r && t < N + r + m_nv) ec |= (1 << r);
        end
      end
    end else if (m_mode == 2) begin
      ed = 1;
    end
    chk("busy", busy, eb);
    chk("done", done, ed);
    chk("pe_load", pe_load, ep);
    chk("act_rd_en", act_rd_en, eae);
    chk("act_row_en", int'(act_row_en), er);
    chk("res_col_valid", int'(res_col_valid), ec);
`ifdef SYSTOLIC_PERF_CNT_EN
    chk("perf_cycles", longint'(perf_cycles), m_perf);
`endif
    if (rec_j >= 0 && rec_j < 32) begin
      ob_busy[rec_j] = busy;
      ob_pl[rec_j]   = pe_load;
      ob_wa[rec_j]   = int'(w_rd_addr);
      ob_done[rec_j] = done;
      ob_ae[rec_j]   = act_rd_en;
      ob_aa[rec_j]   = int'(act_rd_addr);
      ob_r3[rec_j]   = act_row_en[3];
      ob_c0[rec_j]   = res_col_valid[0];
      ob_c3[rec_j]   = res_col_valid[3];
`ifdef SYSTOLIC_PERF_CNT_EN
      ob_perf[rec_j] = longint'(perf_cycles);
`else
      ob_perf[rec_j] = 0;
`endif
    end
  endtask

  task automatic advance(input bit s, input int nv, input bit ab);
    bit acc;
    acc = 1'b0;
    if (m_mode == 1 && m_perf != 64'hFFFF_FFFF) m_perf++;
    case (m_mode)
      0: if (s) begin
        acc = 1'b1;
        m_nv = nv;
        if (nv != 0) begin m_mode = 1; m_k = 1; end
        else m_mode = 2;
      end
      1: begin
        if (ab || m_k == L + m_nv + 2 * N - 1) m_mode = 2;
        else m_k++;
      end
      default: m_mode = 0;
    endcase
    if (acc) m_perf = 0;
  endtask

  // one cycle: check current outputs, drive inputs, step model
  task automatic step(input bit s, input int nv, input bit ab);
    compare();
    if (rec_j >= 0) rec_j++;
    start = s;
    num_vecs = VW'(nv);
    abort = ab;
    advance(s, nv, ab);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pe_load"}, pe_load, 0);
    chk({tag, "_w_rd_addr"}, int'(w_rd_addr), 0);
    chk({tag, "_act_rd_en"}, act_rd_en, 0);
    chk({tag, "_act_rd_addr"}, int'(act_rd_addr), 0);
    chk({tag, "_act_row_en"}, int'(act_row_en), 0);
    chk({tag, "_res_col_valid"}, int'(res_col_valid), 0);
`ifdef SYSTOLIC_PERF_CNT_EN
    chk({tag, "_perf"}, longint'(perf_cycles), 0);
`endif
  endtask

  initial begin
    int cnt;
    int wexp[4];
    int s, nv, ab;
    wexp = '{3, 2, 1, 0};

    #1;
    chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // directed job, num_vecs = 3
    rec_j = 0;
    step(1, 3, 0);
    repeat (20) step(0, 0, 0);
    rec_j = -1;
    chk("lit_busy_j0", ob_busy[0], 0);
    chk("lit_busy_j1", ob_busy[1], 1);
    cnt = 0;
    for (int j = 0; j <= 20; j++) cnt += ob_pl[j];
    chk("lit_pe_load_cycles", cnt, 7);
    chk("lit_pe_load_j7", ob_pl[7], 1);
    for (int i = 0; i < 4; i++)
      chk("lit_w_rd_addr", ob_wa[1 + 2 * i], wexp[i]);
    for (int i = 0; i < 3; i++) begin
      chk("lit_act_rd_en", ob_ae[8 + i], 1);
      chk("lit_act_rd_addr", ob_aa[8 + i], i);
    end
    chk("lit_act_rd_en_off", ob_ae[11], 0);
    cnt = 0;
    for (int j = 0; j <= 20; j++) cnt += ob_r3[j];
    chk("lit_row3_cycles", cnt, 3);
    chk("lit_row3_first", ob_r3[11], 1);
    chk("lit_row3_last", ob_r3[13], 1);
    chk("lit_col0_first", ob_c0[12], 1);
    chk("lit_col0_last", ob_c0[14], 1);
    chk("lit_col0_after", ob_c0[15], 0);
    chk("lit_col3_first", ob_c3[15], 1);
    chk("lit_col3_last", ob_c3[17], 1);
    chk("lit_col3_after", ob_c3[18], 0);
    chk("lit_done_j18", ob_done[18], 1);
    cnt = 0;
    for (int j = 0; j <= 20; j++) cnt += ob_done[j];
    chk("lit_done_pulses", cnt, 1);
`ifdef SYSTOLIC_PERF_CNT_EN
    chk("lit_perf_17", ob_perf[18], 17);
    chk("lit_perf_hold", ob_perf[20], 17);
`endif

    // num_vecs = 0: straight to DONE
    step(1, 0, 0);
    chk("lit_nv0_done", done, 1);
    chk("lit_nv0_busy", busy, 0);
    step(0, 0, 0);
    step(0, 0, 0);

    // abort at STREAM t=1
    step(1, 5, 0);
    repeat (8) step(0, 0, 0);
    chk("lit_pre_abort_en", act_rd_en, 1);
    step(0, 0, 1);
    chk("lit_abort_done", done, 1);
    chk("lit_abort_rd_en", act_rd_en, 0);
    chk("lit_abort_row", int'(act_row_en), 0);
    chk("lit_abort_res", int'(res_col_valid), 0);
    step(0, 0, 0);
    chk("lit_abort_idle", busy | done, 0);
    step(0, 0, 0);

    // async reset in DRAIN
    step(1, 2, 0);
    repeat (12) step(0, 0, 0);
    chk("lit_pre_reset_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    m_mode = 0; m_k = 0; m_nv = 0; m_perf = 0;
    @(negedge clk);
    reset = 1'b0;
    step(1, 2, 0);
    repeat (20) step(0, 0, 0);

    // randomized jobs, occasional long jobs and aborts
    for (int i = 0; i < 1500; i++) begin
      s  = ($urandom_range(0, 3) == 0);
      nv = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255)
                                       : $urandom_range(0, 6);
      ab = ($urandom_range(0, 40) == 0);
      step(s[0], nv, ab[0]);
    end
    repeat (300) step(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
